// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Contents: FSM state type, line geometry constants and an address field splitter.
package dcache_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned LADDR_W    = 14;  // line address {tag, index}

  typedef enum logic [1:0] {
    StIdle,
    StWb,
    StFill
  } state_e;

  // Tag and index are returned at full line-address width; callers cast to their widths.
  typedef struct packed {
    logic [LADDR_W-1:0] tag;
    logic [LADDR_W-1:0] index;
    logic [1:0]         word;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr,
                                              input int unsigned idx_w);
    addr_fields_t       f;
    logic [LADDR_W-1:0] laddr;
    laddr   = addr[15:2];
    f.word  = addr[1:0];
    f.index = laddr & ((14'd1 << idx_w) - 14'd1);
    f.tag   = laddr >> idx_w;
    return f;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache.
// slave  : the cache view (takes CPU request and memory response, drives data/stall/strobes).
// master : the environment view (CPU pipeline plus main memory).
interface dcache_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic               re;
  logic               we;
  logic [WORD_W-1:0]  wrt_data;
  logic [WORD_W-1:0]  rd_data;
  logic               stall;
  logic [LADDR_W-1:0] mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_rdy;

  modport slave (
    input  addr, re, we, wrt_data, mem_rdata, mem_rdy,
    output rd_data, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output addr, re, we, wrt_data, mem_rdata, mem_rdy,
    input  rd_data, stall, mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// Storage for the data cache: per-line valid, dirty, tag and 4-word data.
// Ports: clk, rst_n (async, active-low; clears valid/dirty only);
//   rd_idx_i -> rd_valid_o/rd_dirty_o/rd_tag_o/rd_line_o  combinational read port;
//   wr_idx_i with word_we_i (word write, sets dirty) or line_we_i (install, clears dirty).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = 14 - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              word_we_i,
  input  logic [1:0]        word_sel_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              line_we_i,
  input  logic [TAG_W-1:0]  line_tag_i,
  input  logic [LINE_W-1:0] line_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags and data are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= line_tag_i;
      data_q[wr_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][{word_sel_i, 4'b0000} +: WORD_W] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports: clk, rst_n (async, active-low); bus_io (dcache_if.slave) carrying the CPU request
//   (addr/re/we/wrt_data -> rd_data/stall) and the line-wide memory handshake
//   (mem_addr/mem_re/mem_we/mem_wdata -> mem_rdata/mem_rdy).
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8
) (
  input logic     clk,
  input logic     rst_n,
  dcache_if.slave bus_io
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 14 - IDX_W;

  state_e             state_q, state_d;
  logic [LADDR_W-1:0] miss_laddr_q, miss_laddr_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic [LADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;

  addr_fields_t      fields;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req;
  logic              hit;
  logic              vic_valid, vic_dirty;
  logic [TAG_W-1:0]  vic_tag;
  logic [LINE_W-1:0] vic_line;
  logic [WORD_W-1:0] hit_word;
  logic [IDX_W-1:0]  wr_idx;
  logic              word_we, line_we;
  logic              stall;
  logic [WORD_W-1:0] rd_data;

  assign fields   = split_addr(bus_io.addr, IDX_W);
  assign req_idx  = IDX_W'(fields.index);
  assign req_tag  = TAG_W'(fields.tag);
  assign req      = bus_io.re | bus_io.we;
  assign hit      = vic_valid && (vic_tag == req_tag);
  assign hit_word = vic_line[{fields.word, 4'b0000} +: WORD_W];
  // Installs target the latched miss index; word writes only happen in idle on the live index.
  assign wr_idx   = (state_q == StFill) ? miss_laddr_q[IDX_W-1:0] : req_idx;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (req_idx),
    .rd_valid_o  (vic_valid),
    .rd_dirty_o  (vic_dirty),
    .rd_tag_o    (vic_tag),
    .rd_line_o   (vic_line),
    .wr_idx_i    (wr_idx),
    .word_we_i   (word_we),
    .word_sel_i  (fields.word),
    .word_data_i (bus_io.wrt_data),
    .line_we_i   (line_we),
    .line_tag_i  (miss_laddr_q[LADDR_W-1:IDX_W]),
    .line_data_i (bus_io.mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    miss_laddr_d = miss_laddr_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    stall        = 1'b0;
    rd_data      = '0;
    word_we      = 1'b0;
    line_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && hit) begin
          word_we = bus_io.we;
          if (bus_io.re) rd_data = hit_word;
        end else if (req) begin
          stall        = 1'b1;
          miss_laddr_d = bus_io.addr[15:2];
          if (vic_valid && vic_dirty) begin
            state_d     = StWb;
            mem_we_d    = 1'b1;
            mem_addr_d  = {vic_tag, req_idx};
            mem_wdata_d = vic_line;
          end else begin
            state_d    = StFill;
            mem_re_d   = 1'b1;
            mem_addr_d = bus_io.addr[15:2];
          end
        end
      end
      StWb: begin
        stall = 1'b1;
        if (bus_io.mem_rdy) begin
          state_d    = StFill;
          mem_we_d   = 1'b0;
          mem_re_d   = 1'b1;
          mem_addr_d = miss_laddr_q;
        end
      end
      StFill: begin
        stall = 1'b1;
        if (bus_io.mem_rdy) begin
          line_we  = 1'b1;
          state_d  = StIdle;
          mem_re_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      miss_laddr_q <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      miss_laddr_q <= miss_laddr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus_io.stall     = stall;
  assign bus_io.rd_data   = rd_data;
  assign bus_io.mem_re    = mem_re_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a behavioural cache/memory model predicts the stall
// length, read data and memory transactions of every request; a monitor checks the DUT.
module tb_dcache_ctrl;

  localparam int unsigned LINES = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_if bus ();

  dcache_ctrl #(
    .LINES (LINES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  typedef struct {
    bit          we;
    logic [13:0] addr;
    logic [63:0] data;
  } mem_exp_t;

  typedef struct {
    bit          chk_rd;
    logic [15:0] rd;
    int          stall;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int        wait_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;
  int stall_cnt   = 0;

  // Backing store seen by the responder, and the model's own copy of main memory.
  logic [63:0] ext_mem [int];
  logic [63:0] ref_mem [int];

  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int          m_tag   [LINES];
  logic [15:0] m_data  [LINES][4];

  function automatic logic [63:0] line_init(input int a);
    logic [13:0] la;
    la = 14'(a);
    return {2'b10, la, 2'b01, la, 2'b11, la, 2'b00, la};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Memory responder: a wait count is taken from wait_q at the start of each strobe.
  bit rsp_busy = 1'b0;
  int rsp_cnt  = 0;
  always @(posedge clk) begin
    #2;
    if (bus.mem_re || bus.mem_we) begin
      if (!rsp_busy) begin
        rsp_busy = 1'b1;
        if (wait_q.size() > 0) rsp_cnt = wait_q.pop_front();
        else rsp_cnt = 0;
      end
      if (rsp_cnt == 0) begin
        rsp_busy    = 1'b0;
        bus.mem_rdy = 1'b1;
        if (bus.mem_we) begin
          ext_mem[int'(bus.mem_addr)] = bus.mem_wdata;
        end else begin
          if (!ext_mem.exists(int'(bus.mem_addr)))
            ext_mem[int'(bus.mem_addr)] = line_init(int'(bus.mem_addr));
          bus.mem_rdata = ext_mem[int'(bus.mem_addr)];
        end
      end else begin
        rsp_cnt--;
        bus.mem_rdy   = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
      end
    end else begin
      rsp_busy      = 1'b0;
      bus.mem_rdy   = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: checks memory-side strobes every cycle and CPU responses on completion.
  always @(negedge clk) begin : monitor
    mem_exp_t  me;
    resp_exp_t re;
    if (mon_en && rst_n) begin
      check("strobe_exclusive", 64'(bus.mem_re & bus.mem_we), 64'(0));
      if (bus.mem_re || bus.mem_we) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", 64'(mem_q.size()), 64'(1));
        end else begin
          me = mem_q[0];
          check("mem_strobe", 64'({bus.mem_re, bus.mem_we}), 64'({~me.we, me.we}));
          check("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
          if (me.we) check("mem_wdata", bus.mem_wdata, me.data);
          if (bus.mem_rdy) void'(mem_q.pop_front());
        end
      end
      if (bus.re || bus.we) begin
        if (bus.stall) begin
          stall_cnt++;
        end else begin
          if (resp_q.size() == 0) begin
            check("resp_unexpected", 64'(resp_q.size()), 64'(1));
          end else begin
            re = resp_q.pop_front();
            check("stall_cycles", 64'(stall_cnt), 64'(re.stall));
            if (re.chk_rd) check("rd_data", 64'(bus.rd_data), 64'(re.rd));
          end
          stall_cnt = 0;
        end
      end else begin
        check("idle_stall", 64'(bus.stall), 64'(0));
        check("idle_rd_data", 64'(bus.rd_data), 64'(0));
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.stall) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL timeout: stall still %b after 60 cycles, required 0", bus.stall);
    finish_sim();
  endtask

  // Predict the request with the model, queue expectations, then drive it.
  task automatic do_req(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input int wwb, input int wfill);
    int          la, idx, tag, vla;
    bit          hit;
    logic [63:0] line;
    logic [1:0]  wd;
    resp_exp_t   e;
    mem_exp_t    m;
    la  = int'(a >> 2);
    idx = la % LINES;
    tag = la / LINES;
    wd  = a[1:0];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    e.stall  = 0;
    e.chk_rd = r && !w;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vla  = m_tag[idx] * LINES + idx;
        line = {m_data[idx][3], m_data[idx][2], m_data[idx][1], m_data[idx][0]};
        ref_mem[vla] = line;
        m.we   = 1'b1;
        m.addr = 14'(vla);
        m.data = line;
        mem_q.push_back(m);
        wait_q.push_back(wwb);
        e.stall += 1 + wwb;
      end
      m.we   = 1'b0;
      m.addr = 14'(la);
      m.data = '0;
      mem_q.push_back(m);
      wait_q.push_back(wfill);
      e.stall += 2 + wfill;
      if (!ref_mem.exists(la)) ref_mem[la] = line_init(la);
      line = ref_mem[la];
      for (int k = 0; k < 4; k++) m_data[idx][k] = line[16*k +: 16];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    if (w) begin
      m_data[idx][wd] = d;
      m_dirty[idx]    = 1'b1;
    end
    e.rd = m_data[idx][wd];
    resp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.re       = r;
    bus.we       = w;
    bus.addr     = a;
    bus.wrt_data = d;
    wait_done();
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    bus.re       = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = 16'($urandom);
    bus.wrt_data = 16'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.re        = 1'b0;
    bus.we        = 1'b0;
    bus.addr      = '0;
    bus.wrt_data  = '0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    #1;
    check("reset_stall", 64'(bus.stall), 64'(0));
    check("reset_mem_re", 64'(bus.mem_re), 64'(0));
    check("reset_mem_we", 64'(bus.mem_we), 64'(0));
    check("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("reset_mem_wdata", bus.mem_wdata, 64'(0));
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed scenarios.
    ext_mem[4] = 64'h4444_3333_2222_1111;
    ref_mem[4] = 64'h4444_3333_2222_1111;
    do_req(1'b1, 1'b0, 16'h0012, 16'h0000, 0, 0);  // cold miss, rd 0x3333
    do_req(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0, 0);  // write hit
    do_req(1'b1, 1'b0, 16'h0012, 16'h0000, 0, 0);  // read back 0xBEEF
    do_req(1'b1, 1'b0, 16'h0032, 16'h0000, 0, 0);  // dirty eviction of line 0x004
    do_req(1'b1, 1'b0, 16'h0072, 16'h0000, 0, 3);  // fill with 3 wait cycles
    idle_cycle();

    // Reset in the second fill cycle.
    mon_en = 1'b0;
    wait_q.push_back(5);
    @(posedge clk);
    #1;
    bus.re   = 1'b1;
    bus.addr = 16'h001C;
    @(negedge clk);
    @(negedge clk);
    check("fill_strobe_up", 64'(bus.mem_re), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_drops_mem_re", 64'(bus.mem_re), 64'(0));
    check("reset_clears_mem_addr", 64'(bus.mem_addr), 64'(0));
    bus.re = 1'b0;
    #1;
    check("reset_stall_low", 64'(bus.stall), 64'(0));
    mem_q.delete();
    resp_q.delete();
    wait_q.delete();
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    stall_cnt = 0;
    mon_en    = 1'b1;
    do_req(1'b1, 1'b0, 16'h001C, 16'h0000, 0, 0);  // misses again
    do_req(1'b1, 1'b1, 16'h001D, 16'h1234, 0, 0);  // re & we hit acts as write
    do_req(1'b1, 1'b0, 16'h001D, 16'h0000, 0, 0);
    do_req(1'b1, 1'b0, 16'h003C, 16'h0000, 1, 0);  // evicts the dirtied line
    idle_cycle();

    // Randomised traffic over a few tags per index to force conflicts.
    for (int n = 0; n < 400; n++) begin
      int          tag, idx, wd, op;
      logic [15:0] a;
      tag = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, LINES - 1));
      wd  = int'($urandom_range(0, 3));
      op  = int'($urandom_range(0, 2));
      a   = 16'((tag * LINES + idx) * 4 + wd);
      do_req(op != 1, op != 0, a, 16'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(mem_q.size() + resp_q.size()), 64'(0));
    finish_sim();
  end

endmodule
